// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: matches the most recent len_q accepted bits against a latched pattern.
// Optional macro PATDET_SATURATE_EN makes match_count saturate instead of wrapping.
module pattern_detector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             disarm,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       pat_len,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             detect,
    output logic [CNT_W-1:0] match_count,
    output logic             busy
);

    localparam int LEN_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               detect_q, detect_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [LEN_W-1:0]   len_arm;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic               hit;

    // Clamp the requested length into 1..WIDTH at arm time.
    always_comb begin
        len_arm = LEN_W'(pat_len);
        if (pat_len == 4'd0)
            len_arm = LEN_W'(1);
        else if (int'(pat_len) > WIDTH)
            len_arm = LEN_W'(WIDTH);
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++)
            mask[i] = (i < int'(len_q));
    end

    always_comb begin
        hist_n = WIDTH'({hist_q, bit_in});
        fill_n = (fill_q == len_q) ? len_q : fill_q + LEN_W'(1);
        hit    = (fill_n == len_q) && ((hist_n & mask) == (pat_q & mask));
    end

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        detect_d = 1'b0;
        cnt_d    = cnt_q;

        if (arm) begin
            pat_d   = pattern;
            len_d   = len_arm;
            ovl_d   = overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (disarm) begin
            state_d = IDLE;
        end else if (state_q != IDLE && bit_valid) begin
            hist_d = hist_n;
            fill_d = fill_n;
            if (fill_n == len_q)
                state_d = HUNT;
            if (hit) begin
                detect_d = 1'b1;
`ifdef PATDET_SATURATE_EN
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_d = cnt_q + CNT_W'(1);
`else
                cnt_d = cnt_q + CNT_W'(1);
`endif
                // Non-overlap: restart the fill so old history bits can never be reused.
                if (!ovl_q) begin
                    fill_d  = '0;
                    state_d = FILL;
                end
            end
        end

        if (clr_cnt)
            cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hist_q   <= '0;
            fill_q   <= '0;
            pat_q    <= '0;
            len_q    <= '0;
            ovl_q    <= 1'b0;
            detect_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            detect_q <= detect_d;
            cnt_q    <= cnt_d;
        end
    end

    assign detect      = detect_q;
    assign match_count = cnt_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector (WIDTH=8, CNT_W=2 so the counter boundary is reachable).
module tb_pattern_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm, disarm, bit_valid, bit_in, overlap, clr_cnt;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       detect;
    logic [1:0] match_count;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pattern_detector #(.WIDTH(8), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .arm(arm), .disarm(disarm),
        .bit_valid(bit_valid), .bit_in(bit_in), .pattern(pattern),
        .pat_len(pat_len), .overlap(overlap), .clr_cnt(clr_cnt),
        .detect(detect), .match_count(match_count), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic do_arm(input logic [7:0] p, input logic [3:0] l, input logic o);
        pattern = p;
        pat_len = l;
        overlap = o;
        arm     = 1'b1;
        step();
        arm     = 1'b0;
    endtask

    task automatic do_clr();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arm = 0; disarm = 0; bit_valid = 0; bit_in = 0; overlap = 0; clr_cnt = 0;
        pattern = '0; pat_len = '0;
        step(); step();
        rst = 1'b0;
        step();
        total++;
        if (detect !== 1'b0 || match_count !== 2'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: got det=%b cnt=%0d busy=%b want 0 0 0", detect, match_count, busy);
        end
    endtask

    task automatic test_overlap();
        int s[7] = '{1, 0, 1, 1, 0, 1, 1};
        int e[7] = '{0, 0, 0, 1, 0, 0, 1};
        do_arm(8'h0B, 4'd4, 1'b1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL overlap busy: got %b want 1", busy);
        end
        // Inputs changed after arming must be ignored.
        pattern = 8'hFF; pat_len = 4'd1; overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_bit(s[i][0]);
            total++;
            if (detect !== e[i][0]) begin
                bad++;
                $display("FAIL overlap det[%0d]: got %b want %b", i, detect, e[i][0]);
            end
        end
        total++;
        if (match_count !== 2'd2) begin
            bad++;
            $display("FAIL overlap count: got %0d want 2", match_count);
        end
        step();
        total++;
        if (detect !== 1'b0) begin
            bad++;
            $display("FAIL overlap pulse width: got %b want 0", detect);
        end
    endtask

    task automatic test_non_overlap();
        int s[7] = '{1, 0, 1, 1, 0, 1, 1};
        int e[7] = '{0, 0, 0, 1, 0, 0, 0};
        do_clr();
        do_arm(8'h0B, 4'd4, 1'b0);
        for (int i = 0; i < 7; i++) begin
            send_bit(s[i][0]);
            total++;
            if (detect !== e[i][0]) begin
                bad++;
                $display("FAIL nonovl det[%0d]: got %b want %b", i, detect, e[i][0]);
            end
        end
        total++;
        if (match_count !== 2'd1) begin
            bad++;
            $display("FAIL nonovl count: got %0d want 1", match_count);
        end
    endtask

    task automatic test_clamp();
        int s0[4] = '{1, 1, 0, 1};
        int s1[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        int e1[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        do_clr();
        do_arm(8'h01, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_bit(s0[i][0]);
            total++;
            if (detect !== s0[i][0]) begin
                bad++;
                $display("FAIL clamp0 det[%0d]: got %b want %b", i, detect, s0[i][0]);
            end
        end
        total++;
        if (match_count !== 2'd3) begin
            bad++;
            $display("FAIL clamp0 count: got %0d want 3", match_count);
        end
        do_clr();
        do_arm(8'hA5, 4'd12, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(s1[i][0]);
            total++;
            if (detect !== e1[i][0]) begin
                bad++;
                $display("FAIL clamp12 det[%0d]: got %b want %b", i, detect, e1[i][0]);
            end
        end
        total++;
        if (match_count !== 2'd1) begin
            bad++;
            $display("FAIL clamp12 count: got %0d want 1", match_count);
        end
    endtask

    task automatic test_rearm_disarm();
        int s[4] = '{1, 0, 1, 1};
        do_clr();
        do_arm(8'h0B, 4'd4, 1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        // Re-arm with a bit presented in the same cycle: the bit is dropped.
        pattern = 8'h0B; pat_len = 4'd4; overlap = 1'b1;
        arm = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        step();
        arm = 1'b0; bit_valid = 1'b0;
        send_bit(1'b1);
        total++;
        if (detect !== 1'b0) begin
            bad++;
            $display("FAIL rearm det: got %b want 0", detect);
        end
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        total++;
        if (detect !== 1'b1 || match_count !== 2'd1) begin
            bad++;
            $display("FAIL rearm match: got det=%b cnt=%0d want 1 1", detect, match_count);
        end
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL disarm busy: got %b want 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            send_bit(s[i][0]);
            total++;
            if (detect !== 1'b0) begin
                bad++;
                $display("FAIL disarm det[%0d]: got %b want 0", i, detect);
            end
        end
        total++;
        if (match_count !== 2'd1) begin
            bad++;
            $display("FAIL disarm count hold: got %0d want 1", match_count);
        end
    endtask

    task automatic test_async_reset();
        do_clr();
        do_arm(8'h01, 4'd1, 1'b1);
        send_bit(1'b1);
        total++;
        if (detect !== 1'b1 || match_count !== 2'd1) begin
            bad++;
            $display("FAIL prereset: got det=%b cnt=%0d want 1 1", detect, match_count);
        end
        bit_valid = 1'b1; bit_in = 1'b1;
        #2 rst = 1'b1;
        #1;
        total++;
        if (detect !== 1'b0 || match_count !== 2'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async reset: got det=%b cnt=%0d busy=%b want 0 0 0", detect, match_count, busy);
        end
        step();
        rst = 1'b0; bit_valid = 1'b0;
        step();
        total++;
        if (detect !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post reset: got det=%b busy=%b want 0 0", detect, busy);
        end
    endtask

    task automatic test_counter_boundary();
        logic [1:0] want;
`ifdef PATDET_SATURATE_EN
        want = 2'd3;
`else
        want = 2'd0;
`endif
        do_clr();
        do_arm(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
            total++;
            if (detect !== 1'b1) begin
                bad++;
                $display("FAIL boundary det[%0d]: got %b want 1", i, detect);
            end
        end
        total++;
        if (match_count !== want) begin
            bad++;
            $display("FAIL boundary count: got %0d want %0d", match_count, want);
        end
    endtask

    task automatic test_clr_coincident();
        do_clr();
        send_bit(1'b1);
        total++;
        if (match_count !== 2'd1) begin
            bad++;
            $display("FAIL clr setup count: got %0d want 1", match_count);
        end
        clr_cnt = 1'b1;
        send_bit(1'b1);
        clr_cnt = 1'b0;
        total++;
        if (detect !== 1'b1 || match_count !== 2'd0) begin
            bad++;
            $display("FAIL clr coincident: got det=%b cnt=%0d want 1 0", detect, match_count);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_clamp();
        test_rearm_disarm();
        test_async_reset();
        test_counter_boundary();
        test_clr_coincident();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Serial bit-pattern detector that sits directly downstream of the 8-bit shift register in the sequence-detector path. It consumes one serial bit per qualified cycle, such as the register's shifted-out bit or any serial source. It matches the most recent `pat_len` bits against a programmable pattern, pulses `detect` on each hit, and keeps a running match count. It supports overlapping and non-overlapping detection, selected at arm time.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits, and the width of the history register.
- `CNT_W`, default 8: width of the match counter.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `arm`  in  1  one-cycle strobe; latches `pattern`, `pat_len` and `overlap`, then starts a search.
- `disarm`  in  1  one-cycle strobe; returns the block to IDLE.
- `bit_valid`  in  1  qualifies `bit_in` this cycle.
- `bit_in`  in  1  serial data bit.
- `pattern`  in  WIDTH  pattern; bit 0 is the most recent bit.
- `pat_len`  in  4  pattern length, clamped to 1..WIDTH.
- `overlap`  in  1  1 = overlapping matches allowed.
- `clr_cnt`  in  1  synchronous clear of `match_count`.
- `detect`  out  1  one-cycle match pulse.
- `match_count`  out  CNT_W  number of matches.
- `busy`  out  1  high when not in IDLE.

## Operation
- The latched length `len_q` is `pat_len` clamped: 0 becomes 1, and any value above WIDTH becomes WIDTH.
- History register `hist`:
  - On an accepted bit (`bit_valid` high, state not IDLE), `hist <= {hist[WIDTH-2:0], bit_in}`.
  - Fill counter `fill` increments and saturates at `len_q`.
- The FSM has three states: IDLE, FILL and HUNT.
  - IDLE: bits are ignored, `hist` holds, `busy` = 0. `arm` latches the configuration, clears `hist` and `fill`, and moves to FILL.
  - FILL: accepted bits shift in. When the accepted bit brings `fill` to `len_q`, the match compare runs on that same edge and the state moves to HUNT.
  - HUNT: every accepted bit runs the compare.
- Compare: the low `len_q` bits of the next `hist` value equal the low `len_q` bits of the latched pattern. The compare runs only when the updated `fill` equals `len_q`.
- On a match:
  - `detect` is registered high for one cycle.
  - `match_count` increments.
  - If `overlap` = 1, the state stays in (or enters) HUNT.
  - If `overlap` = 0, `fill` clears to 0 and the state returns to FILL. `hist` keeps its contents, but those stale bits cannot produce a match.
- `arm` while busy restarts the search: it re-latches the configuration, clears `hist` and `fill`, and enters FILL. Any bit presented in that same cycle is discarded.
- `disarm` goes to IDLE and discards any bit in that cycle. `match_count` holds.
- Priority, highest first: `rst`, `arm`, `disarm`, bit processing.
- `clr_cnt` sets `match_count` to 0. If a match occurs in the same cycle, `clr_cnt` wins and the count is 0.
- Changes to `pattern`, `pat_len` or `overlap` after arming have no effect until the next `arm`.

## Timing
- Reset values: `detect` = 0, `match_count` = 0, `busy` = 0, state = IDLE, `hist` = 0, `fill` = 0, latched configuration = 0.
- Latency: `detect` is high in the cycle immediately after the edge that accepted the completing bit. The pulse lasts exactly one cycle.
- `match_count` updates on that same edge, so it is visible together with `detect`.
- Back-to-back matches are possible with `overlap` = 1 and `len_q` = 1. `detect` then stays high on consecutive cycles, one cycle per match.
- `busy` rises the cycle after `arm` and falls the cycle after `disarm`.
- A reset asserted mid-search clears everything asynchronously. No `detect` is produced for the bit being accepted at that moment.

## Configuration
- `PATDET_SATURATE_EN`:
  - Defined: `match_count` saturates at 2^CNT_W−1 and further matches do not change it. `detect` still pulses on every match.
  - Undefined: `match_count` wraps modulo 2^CNT_W.

## Test plan
- Overlap counting: `pattern` = 8'h0B, `pat_len` = 4, `overlap` = 1. Stream 1,0,1,1,0,1,1 -> `detect` after bits 4 and 7; `match_count` = 2.
- Non-overlap counting: same setup with `overlap` = 0 -> `detect` after bit 4 only; `match_count` = 1.
- Length clamping: `pat_len` = 0, `pattern` = 8'h01, stream 1,1,0,1 -> three `detect` pulses, one per 1 bit, the first two on consecutive cycles. `pat_len` = 12 behaves exactly as 8.
- Re-arm, disarm and reset: arm, feed 1,0,1, re-arm, feed 1 -> no `detect`. `disarm` -> `busy` = 0 and bits are ignored. `rst` pulsed mid-stream -> all outputs 0 immediately.
- Counter boundary: CNT_W = 2 and 4 matches. With `PATDET_SATURATE_EN`: `match_count` = 3. Without it: `match_count` = 0.
- `clr_cnt` coincident with a match -> `match_count` = 0 and `detect` still pulses.
